fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage sitting directly upstream of the program memory.
//  It owns the program counter and drives the memory's ce/rw/addr pins.
//  It captures each 16-bit word the memory returns one clock after the request.
//  It presents that word plus its PC to decode with a valid/ready handshake.
//  It accepts branch redirects from execute.
// PARAMETERS
//  ADDR_WIDTH  8   width of PC / memory address
//  DATA_WIDTH  16  instruction word width
//  RESET_PC    0   PC value loaded on reset
// PORTS
//  clk            in   1           rising-edge clock
//  clr            in   1           reset, asynchronous, active-low
//  run            in   1           1 = fetch enabled; 0 = park in IDLE after current fetch
//  mem_ce         out  1           memory chip enable
//  mem_rw         out  1           memory read/write; constant 1 (read)
//  mem_addr       out  ADDR_WIDTH  memory address (= pc while fetching)
//  mem_data       in   DATA_WIDTH  memory registered read data
//  instr_out      out  DATA_WIDTH  captured instruction word
//  instr_pc       out  ADDR_WIDTH  address instr_out was fetched from
//  instr_valid    out  1           instr_out/instr_pc valid to decode
//  instr_ready    in   1           decode accepts word this cycle
//  redirect_en    in   1           branch taken; load redirect_addr
//  redirect_addr  in   ADDR_WIDTH  branch target
//  fetch_count    out  16          count of words accepted by decode, saturating
// BEHAVIOUR
//  Reset (clr=0, async): state=IDLE, pc=RESET_PC, mem_ce=0, mem_addr=0,
//   instr_out=0, instr_pc=0, instr_valid=0, fetch_count=0.
//  mem_ce=0 whenever clr=0, because memory contents are cleared during reset.
//  FSM states IDLE, ISSUE, CAPTURE, PRESENT:
//   IDLE: mem_ce=0; go to ISSUE when run=1.
//   ISSUE: mem_ce=1, mem_addr=pc; always go to CAPTURE (memory latches at this edge).
//   CAPTURE: mem_ce=1, mem_addr=pc held; at the edge, instr_out<=mem_data,
//    instr_pc<=pc, pc<=pc+1, instr_valid<=1; go to PRESENT.
//   PRESENT: mem_ce=0; hold instr_out/instr_pc/instr_valid stable until
//    instr_ready=1. Handshake fires on the edge with valid&ready: instr_valid<=0,
//    fetch_count++; go to ISSUE if run=1, else IDLE.
//  Latency: 2 clocks from ISSUE to instr_valid=1; 3 clocks/instruction when
//   instr_ready=1 continuously.
//  PC arithmetic is modulo 2**ADDR_WIDTH; pc=255 increments to 0 (wrap, no flag).
//  fetch_count saturates at 16'hFFFF.
//  redirect_en=1 in any state overrides everything else, including a
//   simultaneous instr_ready:
//   pc<=redirect_addr; instr_valid<=0; next state ISSUE.
//   Any in-flight word is discarded; fetch_count does not increment.
//  run=0 never aborts an in-flight ISSUE/CAPTURE or a PRESENT word; it only
//   blocks the next ISSUE.
//  An asynchronous clr mid-fetch returns the block to IDLE immediately;
//   the partial word is lost.
// TESTING
//  reset, mem[0]=16'h3803, mem[1]=16'h0005, run=1, ready=1 -> valid at cycle 2
//   with instr_out=3803/pc=0; next valid at cycle 5 with 0005/pc=1;
//   fetch_count=2.
//  ready held 0 for 5 cycles in PRESENT -> instr_out stays 3803, mem_ce=0,
//   pc=1, no new ISSUE.
//  redirect_en with addr=8'd17 during CAPTURE of pc=2 -> word from 2 dropped;
//   next valid word is mem[17]=16'h3004 with instr_pc=17.
//  redirect and ready both high in PRESENT -> count unchanged, fetch restarts
//   at the target.
//  redirect to pc=8'hFF, run=1 -> instr_pc=FF, then next instr_pc=00 (wrap).
//  clr pulsed low during ISSUE -> mem_ce=0 and instr_valid=0 immediately;
//   after release, first fetch is from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction fetch stage: owns the PC, drives program-memory
//            ce/rw/addr, captures returned words, hands them to decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  run,
    output logic                  mem_ce,
    output logic                  mem_rw,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect_en,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [15:0]           fetch_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        PRESENT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
    logic                    valid_q, valid_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    w_fetching;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        // A taken branch wins over everything, including a same-cycle handshake.
        if (redirect_en) begin
            pc_d    = redirect_addr;
            valid_d = 1'b0;
            state_d = ISSUE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run) state_d = ISSUE;
                end
                ISSUE: begin
                    state_d = CAPTURE;
                end
                CAPTURE: begin
                    instr_d = mem_data;
                    ipc_d   = pc_q;
                    pc_d    = pc_q + 1'b1;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
                PRESENT: begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                        state_d = run ? ISSUE : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Chip enable is also gated by clr: memory is being cleared during reset.
    assign w_fetching  = (state_q == ISSUE) || (state_q == CAPTURE);
    assign mem_ce      = clr & w_fetching;
    assign mem_rw      = 1'b1;
    assign mem_addr    = w_fetching ? pc_q : '0;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign instr_valid = valid_q;
    assign fetch_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed per-cycle vector table plus reset corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        run = 1'b0;
    logic        mem_ce, mem_rw;
    logic [7:0]  mem_addr;
    logic [15:0] mem_data = '0;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect_en = 1'b0;
    logic [7:0]  redirect_addr = '0;
    logic [15:0] fetch_count;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mem [256];

    fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .RESET_PC(8'h00)) dut (
        .clk(clk), .clr(clr), .run(run),
        .mem_ce(mem_ce), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_en(redirect_en),
        .redirect_addr(redirect_addr), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Registered-read program memory
    always @(posedge clk) begin
        if (mem_ce) mem_data <= mem[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        run, rdy, re;
        logic [7:0]  ra;
        logic        ce;
        logic [7:0]  addr;
        logic        v;
        logic [15:0] iout;
        logic [7:0]  ipc;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [25];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hC000 | 16'(i);
        mem[0]   = 16'h3803;
        mem[1]   = 16'h0005;
        mem[2]   = 16'h1111;
        mem[17]  = 16'h3004;
        mem[255] = 16'hAAFF;

        //          run rdy re ra      ce addr   v  iout      ipc    cnt
        tbl[0]  = '{1, 1, 0, 8'h00,  0, 8'h00, 0, 16'h0000, 8'h00, 16'd0};
        tbl[1]  = '{1, 1, 0, 8'h00,  1, 8'h00, 0, 16'h0000, 8'h00, 16'd0};
        tbl[2]  = '{1, 1, 0, 8'h00,  1, 8'h00, 0, 16'h0000, 8'h00, 16'd0};
        tbl[3]  = '{1, 1, 0, 8'h00,  0, 8'h00, 1, 16'h3803, 8'h00, 16'd0};
        tbl[4]  = '{1, 0, 0, 8'h00,  1, 8'h01, 0, 16'h3803, 8'h00, 16'd1};
        tbl[5]  = '{1, 0, 0, 8'h00,  1, 8'h01, 0, 16'h3803, 8'h00, 16'd1};
        tbl[6]  = '{1, 0, 0, 8'h00,  0, 8'h00, 1, 16'h0005, 8'h01, 16'd1};
        tbl[7]  = '{1, 0, 0, 8'h00,  0, 8'h00, 1, 16'h0005, 8'h01, 16'd1};
        tbl[8]  = '{1, 0, 0, 8'h00,  0, 8'h00, 1, 16'h0005, 8'h01, 16'd1};
        tbl[9]  = '{1, 0, 0, 8'h00,  0, 8'h00, 1, 16'h0005, 8'h01, 16'd1};
        tbl[10] = '{1, 0, 0, 8'h00,  0, 8'h00, 1, 16'h0005, 8'h01, 16'd1};
        tbl[11] = '{1, 1, 0, 8'h00,  0, 8'h00, 1, 16'h0005, 8'h01, 16'd1};
        tbl[12] = '{1, 1, 0, 8'h00,  1, 8'h02, 0, 16'h0005, 8'h01, 16'd2};
        tbl[13] = '{1, 1, 1, 8'd17,  1, 8'h02, 0, 16'h0005, 8'h01, 16'd2};
        tbl[14] = '{1, 1, 0, 8'h00,  1, 8'd17, 0, 16'h0005, 8'h01, 16'd2};
        tbl[15] = '{1, 1, 0, 8'h00,  1, 8'd17, 0, 16'h0005, 8'h01, 16'd2};
        tbl[16] = '{1, 1, 1, 8'hFF,  0, 8'h00, 1, 16'h3004, 8'd17,  16'd2};
        tbl[17] = '{1, 1, 0, 8'h00,  1, 8'hFF, 0, 16'h3004, 8'd17,  16'd2};
        tbl[18] = '{1, 1, 0, 8'h00,  1, 8'hFF, 0, 16'h3004, 8'd17,  16'd2};
        tbl[19] = '{1, 1, 0, 8'h00,  0, 8'h00, 1, 16'hAAFF, 8'hFF, 16'd2};
        tbl[20] = '{1, 1, 0, 8'h00,  1, 8'h00, 0, 16'hAAFF, 8'hFF, 16'd3};
        tbl[21] = '{0, 1, 0, 8'h00,  1, 8'h00, 0, 16'hAAFF, 8'hFF, 16'd3};
        tbl[22] = '{0, 1, 0, 8'h00,  0, 8'h00, 1, 16'h3803, 8'h00, 16'd3};
        tbl[23] = '{0, 1, 0, 8'h00,  0, 8'h00, 0, 16'h3803, 8'h00, 16'd4};
        tbl[24] = '{0, 1, 0, 8'h00,  0, 8'h00, 0, 16'h3803, 8'h00, 16'd4};

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ce",    32'(mem_ce),      32'd0);
        chk("rst_addr",  32'(mem_addr),    32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_iout",  32'(instr_out),   32'd0);
        chk("rst_ipc",   32'(instr_pc),    32'd0);
        chk("rst_cnt",   32'(fetch_count), 32'd0);
        chk("rst_rw",    32'(mem_rw),      32'd1);
        clr = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            run           = tbl[i].run;
            instr_ready   = tbl[i].rdy;
            redirect_en   = tbl[i].re;
            redirect_addr = tbl[i].ra;
            #1;
            chk($sformatf("v%0d_ce", i),    32'(mem_ce),      32'(tbl[i].ce));
            chk($sformatf("v%0d_addr", i),  32'(mem_addr),    32'(tbl[i].addr));
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(tbl[i].v));
            chk($sformatf("v%0d_iout", i),  32'(instr_out),   32'(tbl[i].iout));
            chk($sformatf("v%0d_ipc", i),   32'(instr_pc),    32'(tbl[i].ipc));
            chk($sformatf("v%0d_cnt", i),   32'(fetch_count), 32'(tbl[i].cnt));
        end

        // clr pulsed during ISSUE: pc=1 at this point
        @(negedge clk);
        run = 1'b1; instr_ready = 1'b0; redirect_en = 1'b0;
        @(posedge clk); #2;
        chk("iss_ce",   32'(mem_ce),   32'd1);
        chk("iss_addr", 32'(mem_addr), 32'd1);
        clr = 1'b0;
        #1;
        chk("clr_ce",    32'(mem_ce),      32'd0);
        chk("clr_valid", 32'(instr_valid), 32'd0);
        chk("clr_addr",  32'(mem_addr),    32'd0);
        chk("clr_cnt",   32'(fetch_count), 32'd0);
        chk("clr_iout",  32'(instr_out),   32'd0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("rel_iss_ce",   32'(mem_ce),   32'd1);
        chk("rel_iss_addr", 32'(mem_addr), 32'd0);
        @(posedge clk); #1;
        chk("rel_cap_ce",   32'(mem_ce),      32'd1);
        chk("rel_cap_v",    32'(instr_valid), 32'd0);
        @(posedge clk); #1;
        chk("rel_pre_v",    32'(instr_valid), 32'd1);
        chk("rel_pre_iout", 32'(instr_out),   32'h3803);
        chk("rel_pre_ipc",  32'(instr_pc),    32'd0);
        chk("rel_pre_ce",   32'(mem_ce),      32'd0);

        // clr while a word is presented drops it at once
        clr = 1'b0;
        #1;
        chk("clrp_valid", 32'(instr_valid), 32'd0);
        chk("clrp_iout",  32'(instr_out),   32'd0);
        @(negedge clk);
        clr = 1'b1;
        run = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
